// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and lane helpers for the cleared dual-port RAM
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // Which source drives read_data: reset value, RAM (with bypass), or out-of-range fill.
  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_CLR  = 2'd2
  } rd_sel_t;

  function automatic int lanes(input int size, input int lane);
    return (size + lane - 1) / lane;
  endfunction

  // Expands a lane mask to bits: data bit bit_idx is enabled by mask lane lane_of(bit_idx).
  function automatic int lane_of(input int bit_idx, input int lane);
    return bit_idx / lane;
  endfunction

endpackage

// File: rtl/dual_port_ram_clr_if.sv
// rtl/dual_port_ram_clr_if.sv - write/read/clear port bundle for dual_port_ram_clr
interface dual_port_ram_clr_if
  import ram_pkg::*;
#(
  parameter int SIZE  = 16,
  parameter int DEPTH = 256,
  parameter int LANE  = 8
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LANES = lanes(SIZE, LANE);

  logic             clear;
  logic             busy;
  logic [AW-1:0]    wr_address;
  logic [SIZE-1:0]  write_data;
  logic [LANES-1:0] write_mask;
  logic             write_en;
  logic [AW-1:0]    rd_address;
  logic             read_en;
  logic [SIZE-1:0]  read_data;
  logic             read_valid;

  modport master (
    output clear, wr_address, write_data, write_mask, write_en, rd_address, read_en,
    input  busy, read_data, read_valid
  );

  modport slave (
    input  clear, wr_address, write_data, write_mask, write_en, rd_address, read_en,
    output busy, read_data, read_valid
  );

endinterface

// File: rtl/ram_core_2p.sv
// rtl/ram_core_2p.sv - bare simple dual-port array, bit-masked write, registered read, no reset
module ram_core_2p #(
  parameter int SIZE  = 16,
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [SIZE-1:0] wdata,
  input  logic [SIZE-1:0] wbits,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [SIZE-1:0] rdata
);

  logic [SIZE-1:0] mem [DEPTH];

  // Kept free of reset so synthesis can map it onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < SIZE; b++) begin
        if (wbits[b]) begin
          mem[waddr][b] <= wdata[b];
        end
      end
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/dual_port_ram_clr.sv
// rtl/dual_port_ram_clr.sv - dual-port RAM with lane masks and clear sequencer; optional RAM_OUT_REG_EN output stage
module dual_port_ram_clr
  import ram_pkg::*;
#(
  parameter int              SIZE        = 16,
  parameter int              DEPTH       = 256,
  parameter int              LANE        = 8,
  parameter int              WRITE_FIRST = 0,
  parameter logic [SIZE-1:0] CLEAR_VALUE = '0
) (
  input  logic               clk,
  input  logic               rst,
  dual_port_ram_clr_if.slave bus
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  state_t          state;
  logic [AW-1:0]   clr_ptr;
  rd_sel_t         sel_q;
  logic [SIZE-1:0] byp_bits_q;
  logic [SIZE-1:0] byp_data_q;
  logic            rv_q;
  logic [SIZE-1:0] ram_rdata;
  logic [SIZE-1:0] rdata_s1;
  logic [SIZE-1:0] wbits;

  logic idle, wr_in, rd_in, wr_ok, rd_acc, rd_ram, hit;

  for (genvar b = 0; b < SIZE; b++) begin : g_mask
    assign wbits[b] = bus.write_mask[lane_of(b, LANE)];
  end

  assign idle   = (state == IDLE);
  assign wr_in  = ({1'b0, bus.wr_address} < DEPTH_W);
  assign rd_in  = ({1'b0, bus.rd_address} < DEPTH_W);
  assign wr_ok  = idle & bus.write_en & wr_in;
  assign rd_acc = idle & bus.read_en;
  assign rd_ram = rd_acc & rd_in;
  assign hit    = (WRITE_FIRST != 0) & wr_ok & rd_ram & (bus.rd_address == bus.wr_address);

  ram_core_2p #(.SIZE(SIZE), .DEPTH(DEPTH)) u_core (
    .clk   (clk),
    .we    (~rst & (~idle | wr_ok)),
    .waddr (idle ? bus.wr_address : clr_ptr),
    .wdata (idle ? bus.write_data : CLEAR_VALUE),
    .wbits (idle ? wbits : {SIZE{1'b1}}),
    .re    (~rst & rd_ram),
    .raddr (bus.rd_address),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR;
      clr_ptr    <= '0;
      sel_q      <= SEL_ZERO;
      byp_bits_q <= '0;
      byp_data_q <= '0;
      rv_q       <= 1'b0;
    end else begin
      rv_q <= rd_acc;
      // The core returns old contents on a collision; the bypass overlays the new lanes.
      if (rd_acc) begin
        sel_q      <= rd_in ? SEL_RAM : SEL_CLR;
        byp_bits_q <= hit ? wbits : '0;
        byp_data_q <= bus.write_data;
      end
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == LAST) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (bus.clear) begin
            state   <= CLEAR;
            clr_ptr <= '0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  always_comb begin
    rdata_s1 = '0;
    case (sel_q)
      SEL_RAM:  rdata_s1 = (ram_rdata & ~byp_bits_q) | (byp_data_q & byp_bits_q);
      SEL_CLR:  rdata_s1 = CLEAR_VALUE;
      default:  rdata_s1 = '0;
    endcase
  end

  assign bus.busy = ~idle;

`ifdef RAM_OUT_REG_EN
  logic [SIZE-1:0] rdata_q2;
  logic            rv_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q2 <= '0;
      rv_q2    <= 1'b0;
    end else begin
      rv_q2 <= rv_q;
      if (rv_q) begin
        rdata_q2 <= rdata_s1;
      end
    end
  end

  assign bus.read_data  = rdata_q2;
  assign bus.read_valid = rv_q2;
`else
  assign bus.read_data  = rdata_s1;
  assign bus.read_valid = rv_q;
`endif

endmodule
